// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers of the E stage.
// Results are computed at issue, held pending, and committed after a fixed busy window.
module muldiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_valid_q, pend_valid_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    // Issue-time arithmetic
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quo_u, rem_u;
    logic [31:0] quo_mag, rem_mag;
    logic [31:0] quo_s, rem_s;
    logic        div_by_zero;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u = {32'b0, src_a} * {32'b0, src_b};

        div_by_zero = (src_b == 32'd0);
        // A dummy divisor of 1 keeps the dividers X-free; the result is dropped anyway.
        div_b = div_by_zero ? 32'd1 : src_b;
        quo_u = src_a / div_b;
        rem_u = src_a % div_b;

        abs_a = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b = div_b[31] ? (~div_b + 32'd1) : div_b;
        quo_mag = abs_a / abs_b;
        rem_mag = abs_a % abs_b;
        // Truncate toward zero; remainder follows the dividend. 0x80000000 / -1 wraps to itself.
        quo_s = (src_a[31] ^ div_b[31]) ? (~quo_mag + 32'd1) : quo_mag;
        rem_s = src_a[31] ? (~rem_mag + 32'd1) : rem_mag;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OpMult: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OpMultu: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OpDiv: begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
            OpDivu: begin
                res_hi = rem_u;
                res_lo = quo_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        OpMult, OpMultu: begin
                            state_d      = StRun;
                            cnt_d        = CntW'(MULT_CYCLES);
                            pend_hi_d    = res_hi;
                            pend_lo_d    = res_lo;
                            pend_valid_d = 1'b1;
                        end
                        OpDiv, OpDivu: begin
                            state_d      = StRun;
                            cnt_d        = CntW'(DIV_CYCLES);
                            pend_hi_d    = res_hi;
                            pend_lo_d    = res_lo;
                            pend_valid_d = ~div_by_zero;
                        end
                        OpMthi:  hi_d = src_a;
                        OpMtlo:  lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d      = StIdle;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        hi        = hi_q;
        lo        = lo_q;
        stall_req = md_use_d & ((state_q == StRun) | start);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a cycle-level behavioural model of HI/LO
// commits, busy windows and the stall request.
module tb_muldiv_sequencer;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    muldiv_sequencer #(
        .MULT_CYCLES(MultN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, pending commit.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    int          rem    = 0;
    logic [31:0] pend_hi = 32'd0;
    logic [31:0] pend_lo = 32'd0;
    logic        pend_ok = 1'b0;
    logic        obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void compute(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic ok,
                                    output logic [31:0] rh, output logic [31:0] rl);
        longint          sp, sq, sr;
        longint unsigned up;
        ok = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            3'd0: begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                rh = up[63:32];
                rl = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    sq = longint'(signed'(a)) / longint'(signed'(b));
                    sr = longint'(signed'(a)) % longint'(signed'(b));
                    rh = sr[31:0];
                    rl = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    rh = a % b;
                    rl = a / b;
                end
            end
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic s, input logic [2:0] o,
                                       input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            exp_hi = 32'd0;
            exp_lo = 32'd0;
            rem    = 0;
            pend_ok = 1'b0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0 && pend_ok) begin
                exp_hi = pend_hi;
                exp_lo = pend_lo;
            end
        end else if (s) begin
            if (o <= 3'd3) begin
                compute(o, a, b, pend_ok, pend_hi, pend_lo);
                rem = (o <= 3'd1) ? int'(MultN) : int'(DivN);
            end else if (o == 3'd4) begin
                exp_hi = a;
            end else if (o == 3'd5) begin
                exp_lo = a;
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic s, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b, input logic m);
        @(negedge clk);
        reset    = r;
        start    = s;
        op       = o;
        src_a    = a;
        src_b    = b;
        md_use_d = m;
        #1;
        check("busy", {31'b0, busy}, {31'b0, rem > 0});
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        check("stall", {31'b0, stall_req}, {31'b0, m & ((rem > 0) | s)});
        obs_stall = stall_req;
        @(posedge clk);
        model_step(r, s, o, a, b);
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, m);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stall_cnt;
        int busy_cnt;
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        md_use_d = 1'b0;
        repeat (2) @(posedge clk);

        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        // MULT 0xFFFFFFFF * 2
        cycle(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MultN + 1, 1'b0);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFFE);

        // MULTU with D-stage consumer throughout
        stall_cnt = 0;
        cycle(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        stall_cnt += int'(obs_stall);
        for (int i = 0; i < int'(MultN) + 2; i++) begin
            cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            stall_cnt += int'(obs_stall);
        end
        check("t2_stall_cycles", 32'(stall_cnt), 32'd6);
        check("t2_hi", hi, 32'h0000_0001);
        check("t2_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2, then DIVU 7 / 2
        cycle(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DivN + 1, 1'b0);
        check("t3_lo", lo, 32'hFFFF_FFFD);
        check("t3_hi", hi, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
        idle(DivN + 1, 1'b0);
        check("t3u_lo", lo, 32'd3);
        check("t3u_hi", hi, 32'd1);

        // Signed overflow case
        cycle(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DivN + 1, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // MTHI/MTLO preload, then divide by zero
        cycle(1'b0, 1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        cycle(1'b0, 1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        busy_cnt = 0;
        cycle(1'b0, 1'b1, 3'd2, 32'd5, 32'd0, 1'b0);
        for (int i = 0; i < int'(DivN) + 2; i++) begin
            cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            busy_cnt += int'(busy);
        end
        check("t4_busy_cycles", 32'(busy_cnt), 32'(DivN));
        check("t4_hi", hi, 32'h11);
        check("t4_lo", lo, 32'h22);

        // Reset on third busy cycle of a MULT
        cycle(1'b0, 1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        idle(MultN + 1, 1'b0);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd0);

        // DIVU issued while MULT is busy is dropped
        busy_cnt = 0;
        cycle(1'b0, 1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        busy_cnt += int'(busy);
        cycle(1'b0, 1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        busy_cnt += int'(busy);
        for (int i = 0; i < int'(DivN) + 2; i++) begin
            cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            busy_cnt += int'(busy);
        end
        check("t6_busy_cycles", 32'(busy_cnt), 32'(MultN));
        check("t6_lo", lo, 32'd42);
        check("t6_hi", hi, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        idle(DivN + 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
